// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: two-port round-robin arbiter sharing one hyperram_controller.
// It issues single-cycle commands, routes read beats to the owner and reports done/err.
module hyperram_arbiter #(
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [1:0]         we,
  input  logic [1:0]         mem_or_reg,
  input  logic [7:0]         wr_byte_en,
  input  logic [2*CNT_W-1:0] rd_num_dwords,
  input  logic [63:0]        addr,
  input  logic [63:0]        wr_d,
  output logic [1:0]         gnt,
  output logic [31:0]        rd_d,
  output logic [1:0]         rd_rdy,
  output logic [1:0]         done,
  output logic [1:0]         err,
  output logic               ctl_rd_req,
  output logic               ctl_wr_req,
  output logic               ctl_mem_or_reg,
  output logic [3:0]         ctl_wr_byte_en,
  output logic [CNT_W-1:0]   ctl_rd_num_dwords,
  output logic [31:0]        ctl_addr,
  output logic [31:0]        ctl_wr_d,
  input  logic [31:0]        ctl_rd_d,
  input  logic               ctl_rd_rdy,
  input  logic               ctl_busy
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, ACTIVE} state_t;
  state_t state, state_n;
  logic last, owner, sel, cmd_we, cmd_mor, excess;
  logic [3:0] cmd_be;
  logic [CNT_W-1:0] cmd_num, beats;
  logic [31:0] cmd_addr, cmd_wd;
  logic [TW-1:0] tcnt;
  logic [1:0] own_oh;
  logic live, beat_in, beat_ok, fin_to, fin_act;
  assign ctl_mem_or_reg = cmd_mor;
  assign ctl_wr_byte_en = cmd_be;
  assign ctl_rd_num_dwords = cmd_num;
  assign ctl_addr = cmd_addr;
  assign ctl_wr_d = cmd_wd;
  // pulses are gated by reset so an aborted command never reports done
  always_comb begin
    sel = &req ? ~last : req[1];
    own_oh = {owner, ~owner};
    live = ~reset;
    beat_in = (state == WAIT_BUSY || state == ACTIVE) && ctl_rd_rdy && ~cmd_we;
    beat_ok = beat_in && beats != cmd_num;
    fin_to = state == WAIT_BUSY && ~ctl_busy && tcnt == TW'(BUSY_TIMEOUT);
    fin_act = state == ACTIVE && ~ctl_busy;
    state_n = state == IDLE ? ((|req && ~ctl_busy) ? ISSUE : IDLE)
            : state == ISSUE ? WAIT_BUSY
            : ctl_busy ? ACTIVE
            : (state == ACTIVE || fin_to) ? IDLE : WAIT_BUSY;
    gnt = live && state == ISSUE ? own_oh : 2'b00;
    ctl_rd_req = live && state == ISSUE && ~cmd_we;
    ctl_wr_req = live && state == ISSUE && cmd_we;
    done = live && (fin_to || fin_act) ? own_oh : 2'b00;
    err = live && (fin_to || (fin_act && (excess || (beat_in && ~beat_ok)))) ? own_oh : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      owner <= 1'b0;
      cmd_we <= 1'b0;
      cmd_mor <= 1'b0;
      cmd_be <= '0;
      cmd_num <= '0;
      cmd_addr <= '0;
      cmd_wd <= '0;
      beats <= '0;
      excess <= 1'b0;
      tcnt <= '0;
      rd_rdy <= 2'b00;
      rd_d <= '0;
    end else begin
      state <= state_n;
      rd_rdy <= beat_ok ? own_oh : 2'b00;
      if (beat_ok) begin
        rd_d <= ctl_rd_d;
        beats <= beats + 1'b1;
      end
      if (beat_in && ~beat_ok) excess <= 1'b1;
      if (state == IDLE && state_n == ISSUE) begin
        owner <= sel;
        cmd_we <= we[sel];
        cmd_mor <= mem_or_reg[sel];
        cmd_be <= sel ? wr_byte_en[7:4] : wr_byte_en[3:0];
        cmd_num <= sel ? rd_num_dwords[2*CNT_W-1:CNT_W] : rd_num_dwords[CNT_W-1:0];
        cmd_addr <= sel ? addr[63:32] : addr[31:0];
        cmd_wd <= sel ? wr_d[63:32] : wr_d[31:0];
      end
      if (state == ISSUE) begin
        last <= owner;
        beats <= '0;
        excess <= 1'b0;
        tcnt <= '0;
      end
      if (state == WAIT_BUSY) tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: timeline model of grants, command pulses, read beats and completions
// derived from the controller behaviour the bench itself plays, checked every cycle.
module tb_hyperram_arbiter;
  localparam int TO = 16;
  logic clk = 0, reset = 1;
  logic [1:0] req = 0, we = 0, mem_or_reg = 0;
  logic [7:0] wr_byte_en = 0;
  logic [43:0] rd_num_dwords = 0;
  logic [63:0] addr = 0, wr_d = 0;
  logic [1:0] gnt, rd_rdy, done, err;
  logic [31:0] rd_d, ctl_addr, ctl_wr_d;
  logic ctl_rd_req, ctl_wr_req, ctl_mem_or_reg;
  logic [3:0] ctl_wr_byte_en;
  logic [21:0] ctl_rd_num_dwords;
  logic [31:0] ctl_rd_d = 0;
  logic ctl_rd_rdy = 0, ctl_busy = 0;

  hyperram_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mem_or_reg(mem_or_reg),
    .wr_byte_en(wr_byte_en), .rd_num_dwords(rd_num_dwords), .addr(addr), .wr_d(wr_d),
    .gnt(gnt), .rd_d(rd_d), .rd_rdy(rd_rdy), .done(done), .err(err),
    .ctl_rd_req(ctl_rd_req), .ctl_wr_req(ctl_wr_req), .ctl_mem_or_reg(ctl_mem_or_reg),
    .ctl_wr_byte_en(ctl_wr_byte_en), .ctl_rd_num_dwords(ctl_rd_num_dwords),
    .ctl_addr(ctl_addr), .ctl_wr_d(ctl_wr_d), .ctl_rd_d(ctl_rd_d),
    .ctl_rd_rdy(ctl_rd_rdy), .ctl_busy(ctl_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [1:0] gnt, done, err, rdy;
    bit rq, wq, mor, zf;
    bit [3:0] be;
    bit [21:0] num;
    bit [31:0] rdd, a, wd;
  } exp_t;

  exp_t ex[int];
  int cyc = 0, tests = 0, fails = 0;
  int done_cyc = -1, err_cyc = -1;
  int n_rdy[2] = '{0, 0};
  bit gq[$];
  logic [31:0] last_rdd = 0;
  bit last = 1;
  bit pend[2], p_we[2], p_mor[2];
  bit [3:0] p_be[2];
  bit [21:0] p_num[2];
  bit [31:0] p_a[2], p_wd[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [95:0] a, logic [95:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, a, e);
    end
  endtask

  always @(negedge clk) if (cyc >= 1) begin
    exp_t e;
    e = '{default: 0};
    if (ex.exists(cyc)) e = ex[cyc];
    chk("gnt", gnt, e.gnt);
    chk("done", done, e.done);
    chk("err", err, e.err);
    chk("rd_rdy", rd_rdy, e.rdy);
    chk("ctl_rd_wr_req", {ctl_rd_req, ctl_wr_req}, {e.rq, e.wq});
    if (e.rq || e.wq) begin
      chk("ctl_addr", ctl_addr, e.a);
      chk("ctl_wr_d", ctl_wr_d, e.wd);
      chk("ctl_wr_byte_en", ctl_wr_byte_en, e.be);
      chk("ctl_rd_num_dwords", ctl_rd_num_dwords, e.num);
      chk("ctl_mem_or_reg", ctl_mem_or_reg, e.mor);
    end
    if (e.zf) begin
      chk("ctl_fields_zero", {ctl_mem_or_reg, ctl_wr_byte_en, ctl_rd_num_dwords, ctl_addr, ctl_wr_d}, 0);
      last_rdd = 0;
    end
    if (e.rdy != 0) last_rdd = e.rdd;
    chk("rd_d", rd_d, last_rdd);
    n_rdy[0] += int'(rd_rdy[0]);
    n_rdy[1] += int'(rd_rdy[1]);
    if (|gnt) gq.push_back(gnt[1]);
    if (|done) done_cyc = cyc;
    if (|err) err_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req = {pend[1], pend[0]};
    we = {p_we[1], p_we[0]};
    mem_or_reg = {p_mor[1], p_mor[0]};
    wr_byte_en = {p_be[1], p_be[0]};
    rd_num_dwords = {p_num[1], p_num[0]};
    addr = {p_a[1], p_a[0]};
    wr_d = {p_wd[1], p_wd[0]};
  endtask

  task automatic set_cmd(int p, bit w, bit m, bit [3:0] be, bit [21:0] n, bit [31:0] a, bit [31:0] d);
    pend[p] = 1; p_we[p] = w; p_mor[p] = m; p_be[p] = be; p_num[p] = n; p_a[p] = a; p_wd[p] = d;
  endtask

  task automatic new_cmd(int p);
    set_cmd(p, 1'($urandom), 1'($urandom), 4'($urandom), 22'($urandom_range(0, 5)), $urandom, $urandom);
  endtask

  // Starts in an IDLE cycle; plays a controller that raises busy d cycles after WAIT_BUSY
  // entry for len cycles (never if d > TO) and returns up to nb read beats.
  task automatic serve(int d, int len, int nb, int pre, bit keep, bit dense, int rst_at);
    int c, t, i;
    bit w, cwe, xs, b, tmo;
    bit [21:0] cnum;
    ctl_busy = pre > 0;
    drive();
    for (int k = 0; k < pre; k++) begin
      ctl_rd_rdy = 1'($urandom);
      ctl_rd_d = $urandom;
      tick();
    end
    ctl_busy = 0;
    ctl_rd_rdy = 1'($urandom);
    ctl_rd_d = $urandom;
    w = (pend[0] && pend[1]) ? !last : pend[1];
    last = w;
    cwe = p_we[w];
    cnum = p_num[w];
    c = cyc;
    ex[c+1].gnt = w ? 2'b10 : 2'b01;
    ex[c+1].rq = !cwe;
    ex[c+1].wq = cwe;
    ex[c+1].mor = p_mor[w];
    ex[c+1].be = p_be[w];
    ex[c+1].num = cnum;
    ex[c+1].a = p_a[w];
    ex[c+1].wd = p_wd[w];
    tick();
    ctl_rd_rdy = 1'($urandom);
    tick();
    if (!keep) pend[w] = 0;
    drive();
    tmo = d > TO;
    t = tmo ? TO : d + len;
    i = 0;
    xs = 0;
    for (int k = 0; k <= t; k++) begin
      if (k == rst_at) begin
        reset = 1;
        ctl_rd_rdy = 0;
        ex[cyc+1].zf = 1;
        tick();
        reset = 0;
        ctl_busy = 0;
        last = 1;
        return;
      end
      ctl_busy = !tmo && k >= d && k < d + len;
      b = !cwe && i < nb && k <= t - 2 && (rst_at < 0 || k < rst_at - 1) &&
          (dense ? k > d : $urandom_range(0, 2) == 0);
      ctl_rd_rdy = b;
      ctl_rd_d = $urandom;
      if (b) begin
        if (i < int'(cnum)) begin
          ex[cyc+1].rdy = w ? 2'b10 : 2'b01;
          ex[cyc+1].rdd = ctl_rd_d;
        end else xs = 1;
        i++;
      end
      if (k == t) begin
        ex[cyc].done = w ? 2'b10 : 2'b01;
        if (tmo || xs) ex[cyc].err = w ? 2'b10 : 2'b01;
      end
      tick();
    end
    ctl_busy = 0;
    ctl_rd_rdy = 0;
  endtask

  initial begin
    int c0, s0, s1, g0, dc;
    for (int i = 1; i <= 4; i++) ex[i].zf = 1;
    repeat (3) tick();
    reset = 0;
    tick();
    // both ports requesting continuously from reset: 0,1,0,1
    set_cmd(0, 0, 0, 4'h0, 22'd1, 32'h100, 0);
    set_cmd(1, 0, 1, 4'h0, 22'd1, 32'h200, 0);
    g0 = gq.size();
    repeat (4) serve(0, 4, 1, 0, 1, 1, -1);
    chk("grant_count", gq.size() - g0, 4);
    for (int i = 0; i < 4; i++) chk("grant_order", gq[g0 + i], i % 2);
    pend[0] = 0;
    pend[1] = 0;
    // port 0 read of 4, busy 2 cycles after the pulse
    set_cmd(0, 0, 0, 4'h0, 22'd4, 32'h100, 0);
    s0 = n_rdy[0]; s1 = n_rdy[1]; c0 = cyc;
    serve(1, 8, 4, 0, 0, 1, -1);
    chk("p0_read_beats", n_rdy[0] - s0, 4);
    chk("p0_read_p1_beats", n_rdy[1] - s1, 0);
    chk("p0_read_done_cycle", done_cyc, c0 + 11);
    // port 1 write
    set_cmd(1, 1, 0, 4'h3, 22'd0, 32'h300, 32'hDEADBEEF);
    c0 = cyc;
    serve(0, 3, 0, 0, 0, 0, -1);
    chk("p1_write_done_cycle", done_cyc, c0 + 5);
    // busy never rises
    set_cmd(0, 0, 0, 4'h0, 22'd2, 32'h400, 0);
    c0 = cyc;
    serve(20, 1, 0, 0, 0, 0, -1);
    chk("timeout_done_cycle", done_cyc, c0 + 2 + TO);
    chk("timeout_err_cycle", err_cyc, c0 + 2 + TO);
    // read of 2 with 3 beats returned
    set_cmd(0, 0, 0, 4'h0, 22'd2, 32'h500, 0);
    s0 = n_rdy[0]; c0 = cyc;
    serve(0, 6, 3, 0, 0, 1, -1);
    chk("excess_beats", n_rdy[0] - s0, 2);
    chk("excess_err_cycle", err_cyc, c0 + 8);
    // request withdrawn while the controller is busy
    set_cmd(0, 0, 0, 4'h0, 22'd1, 32'h600, 0);
    g0 = gq.size();
    ctl_busy = 1;
    drive();
    repeat (3) tick();
    pend[0] = 0;
    ctl_busy = 0;
    drive();
    repeat (3) tick();
    chk("withdraw_no_grant", gq.size() - g0, 0);
    // reset in ACTIVE mid-read, request held through it
    set_cmd(0, 0, 0, 4'h0, 22'd4, 32'h700, 0);
    dc = done_cyc;
    serve(1, 8, 4, 0, 1, 1, 4);
    chk("reset_no_done", done_cyc, dc);
    g0 = gq.size();
    serve(0, 2, 0, 0, 0, 0, -1);
    chk("reset_regrant", gq.size() - g0, 1);
    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      int d, nb, len;
      if (!pend[0] && !pend[1]) new_cmd(int'($urandom_range(0, 1)));
      for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 1) == 1) new_cmd(p);
      d = ($urandom_range(0, 7) == 0) ? 17 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 16));
      nb = (d > TO) ? 0 : int'($urandom_range(0, 6));
      len = int'($urandom_range(1, 3)) + (nb > 0 ? 2 * nb + 1 : 0);
      serve(d, len, nb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            $urandom_range(0, 2) == 0, 1'($urandom), -1);
    end
    pend[0] = 0;
    pend[1] = 0;
    drive();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
Two-port round-robin arbiter that shares one hyperram_controller between two independent requesters (e.g. a CPU-side port and a DMA/video port).
- Accepts one command per port via a request/grant handshake.
- Issues it to the controller as a single-cycle rd_req/wr_req pulse.
- Tracks the controller's busy window and routes read data back to the owning port.
- Signals completion per port.
Sits between the requesters and hyperram_controller; it never touches the DRAM pins.

Parameters:
BUSY_TIMEOUT, 16, cycles allowed between the command pulse and ctl_busy rising before the command is aborted with an error.
CNT_W, 22, width of the read-beat counter; matches rd_num_dwords.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
req  in  2  per-port command request; bit i = port i; held until gnt[i].
we  in  2  per-port 1 = write, 0 = read.
mem_or_reg  in  2  per-port memory/register space select, passed through.
wr_byte_en  in  8  port i at [4i+3:4i]; write byte enables.
rd_num_dwords  in  44  port i at [22i+21:22i]; read length in dwords.
addr  in  64  port i at [32i+31:32i].
wr_d  in  64  port i at [32i+31:32i]; single-dword write data.
gnt  out  2  one-cycle pulse: command of port i accepted.
rd_d  out  32  read data, shared bus; valid only with rd_rdy.
rd_rdy  out  2  one-cycle read-beat strobe to the owning port.
done  out  2  one-cycle pulse: port i command finished.
err  out  2  one-cycle pulse with done: timeout or excess read beats.
ctl_rd_req, ctl_wr_req  out  1 each  command pulses to the controller.
ctl_mem_or_reg  out  1  to the controller.
ctl_wr_byte_en  out  4  to the controller.
ctl_rd_num_dwords  out  22  to the controller.
ctl_addr, ctl_wr_d  out  32 each  to the controller.
ctl_rd_d  in  32  from the controller.
ctl_rd_rdy, ctl_busy  in  1 each  from the controller.

Behaviour:
Reset values:
- All outputs 0.
- State IDLE.
- Last-served pointer = 1, so port 0 wins the first tie.

States: IDLE -> ISSUE -> WAIT_BUSY -> ACTIVE -> IDLE.

IDLE:
- If any req bit is set and ctl_busy = 0, select the owner.
- With a single requester, that port wins.
- With both requesting, the port not last served wins.
- Latch the owner's we, mem_or_reg, byte enables, num_dwords, addr and wr_d into command registers; go to ISSUE.
- If ctl_busy = 1, stay in IDLE.

ISSUE (exactly one cycle):
- gnt[owner] = 1.
- ctl_rd_req = !we or ctl_wr_req = we; never both.
- ctl_* data outputs driven from the command registers.
- Command registers stay stable until the next ISSUE.
- Update the last-served pointer; clear the beat counter and timeout counter.
- Go to WAIT_BUSY.
- Latency: req sampled in IDLE at cycle N gives gnt and the ctl pulse at N+1.

WAIT_BUSY:
- Timeout counter increments each cycle.
- ctl_busy = 1 -> ACTIVE.
- Counter reaching BUSY_TIMEOUT with ctl_busy still 0 -> done[owner] = err[owner] = 1 for one cycle; go to IDLE.

ACTIVE:
- ctl_busy = 0 -> done[owner] = 1 for one cycle; go to IDLE.
- err is raised with done if the beat count exceeded num_dwords.

Read routing (WAIT_BUSY and ACTIVE):
- Each ctl_rd_rdy beat gives rd_rdy[owner] = 1 and rd_d = ctl_rd_d, registered with 1-cycle latency; beat counter increments.
- Beats beyond num_dwords are dropped (no rd_rdy) and set a sticky excess flag, which is reported at done.
- rd_num_dwords = 0 is forwarded unchanged; any beat that then arrives counts as excess.
- rd_rdy is never asserted during IDLE/ISSUE; ctl_rd_rdy seen in those states is ignored.
- rd_d holds its last value when rd_rdy = 0.

Handshake rules:
- A requester keeps req[i] and its command fields stable until gnt[i].
- It may deassert req or present a new command the cycle after gnt.
- req deasserted before gnt withdraws the request with no side effects.

Boundaries:
- Back-to-back: done in cycle M, IDLE at M+1, next gnt at M+2 at the earliest.
- Under continuous requests from both ports, grants alternate 0,1,0,1.
- Writes are single-dword; burst_wr_rdy is not used.

Reset mid-operation:
- Synchronous reset forces IDLE; all pulses and outputs clear in the same cycle.
- No done is generated for the aborted command.
- The controller is not reset by this block.

Test Plan:
- Port 0 read: rd_num_dwords = 4, addr = 0x100; controller raises busy 2 cycles after the pulse and returns 4 beats -> gnt[0] at N+1, exactly 4 rd_rdy[0] pulses with matching data, done[0] = 1, err = 0, rd_rdy[1] never set.
- Both ports assert req in the same cycle after reset, held continuously -> grant order 0,1,0,1; port 1's ctl_addr = 0x200 and port 0's = 0x100 on their respective ISSUE cycles.
- Port 1 write: wr_byte_en = 0x3, wr_d = 0xDEADBEEF -> single ctl_wr_req pulse with ctl_wr_byte_en = 0x3 and ctl_wr_d = 0xDEADBEEF; no ctl_rd_req; done[1] one cycle after busy falls.
- Controller never raises busy -> done[0] = err[0] = 1 exactly BUSY_TIMEOUT = 16 cycles after WAIT_BUSY entry; arbiter accepts the next request.
- Read of 2 with 3 beats returned -> 2 rd_rdy pulses, third beat dropped, err = 1 with done.
- reset = 1 in ACTIVE mid-read -> all outputs 0 the next cycle, no done; req held asserted is granted again after reset releases.
